spi_slave_param: RTL and testbench

// Next-generation SPI slave: width/mode-parametrised, multi-word per SS frame.

---
 rtl/spi_slave_param.sv | 193 +++++++++++++++++++
 tb/tb_spi_slave_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave with configurable word width, mode and bit order.
// Supports several words per SS frame. All SPI pins are oversampled in the clock domain.
`timescale 1ns/1ps
`default_nettype none

module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              frame_done
);

  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_prev_q, ss_prev_q;
  logic lead_q, trail_q, ss_fall_q, ss_rise_q, mosi_q;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // SS chain resets low so an SS already low at reset release never looks like a fall.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= IDLE_LVL;
      ss_prev_q   <= 1'b0;
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      lead_q      <= (sclk_s != sclk_prev_q) && (sclk_s != IDLE_LVL);
      trail_q     <= (sclk_s != sclk_prev_q) && (sclk_s == IDLE_LVL);
      ss_fall_q   <= ss_prev_q && !ss_s;
      ss_rise_q   <= !ss_prev_q && ss_s;
      mosi_q      <= mosi_s;
    end
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic               hold_full_q, hold_full_d, pend_q, pend_d;
  logic               miso_q, miso_d, rx_valid_q, rx_valid_d;
  logic               underrun_q, underrun_d, frame_done_q, frame_done_d;

  logic               sample_w, shift_w, in_frame_w, word_start_w, pend_now_w;
  logic [DATA_W-1:0]  rx_next_w, load_word_w;

  assign sample_w     = (CPHA != 0) ? trail_q : lead_q;
  assign shift_w      = (CPHA != 0) ? lead_q : trail_q;
  assign in_frame_w   = (state_q == ST_ACTIVE || ss_fall_q) && !ss_rise_q;
  assign word_start_w = in_frame_w &&
                        ((CPHA == 0) ? (state_q == ST_IDLE || (shift_w && bit_cnt_q == '0))
                                     : (shift_w && bit_cnt_q == '0));
  // An empty-holding load only counts as underrun once that word's first bit is sampled,
  // so the speculative load on the final trailing edge of a frame is not reported.
  assign pend_now_w   = word_start_w ? !hold_full_q : pend_q;
  assign rx_next_w    = (MSB_FIRST != 0) ? {rx_shift_q[DATA_W-2:0], mosi_q}
                                         : {mosi_q, rx_shift_q[DATA_W-1:1]};
  assign load_word_w  = hold_full_q ? hold_q : '0;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    pend_d       = pend_q;
    miso_d       = miso_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;

    if (ss_rise_q) begin
      if (state_q == ST_ACTIVE) begin
        state_d      = ST_IDLE;
        frame_done_d = 1'b1;
      end
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      miso_d     = 1'b0;
      pend_d     = 1'b0;
    end else begin
      if (ss_fall_q) state_d = ST_ACTIVE;
      if (in_frame_w) begin
        if (word_start_w) begin
          tx_shift_d  = load_word_w;
          miso_d      = (MSB_FIRST != 0) ? load_word_w[DATA_W-1] : load_word_w[0];
          hold_full_d = 1'b0;
        end else if (shift_w) begin
          miso_d     = (MSB_FIRST != 0) ? tx_shift_q[DATA_W-2] : tx_shift_q[1];
          tx_shift_d = (MSB_FIRST != 0) ? (tx_shift_q << 1) : (tx_shift_q >> 1);
        end
        pend_d = pend_now_w;
        if (sample_w) begin
          rx_shift_d = rx_next_w;
          if (bit_cnt_q == '0 && pend_now_w) begin
            underrun_d = 1'b1;
            pend_d     = 1'b0;
          end
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            rx_data_d  = rx_next_w;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
    end

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      tx_shift_q   <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      pend_q       <= 1'b0;
      miso_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      pend_q       <= pend_d;
      miso_q       <= miso_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign MISO        = miso_q;
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == ST_ACTIVE);
  assign tx_underrun = underrun_q;
  assign frame_done  = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: six instances cover 8-bit mode 0, all four
// 16-bit modes and a 16-bit LSB-first slave, each driven by its own SCLK/SS.
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_param;
  localparam int N = 6;
  localparam int T = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sclk [N];
  logic        ss   [N];
  logic        mosi;
  logic [15:0] txd  [N];
  logic        txv  [N];
  wire         miso_w [N], txr [N], rxv [N], bsy [N], und [N], fdn [N];
  wire  [15:0] rxw [N];

  function automatic int wid_of(input int k);  return (k == 0) ? 8 : 16;   endfunction
  function automatic int cpol_of(input int k); return (k == 3 || k == 4) ? 1 : 0; endfunction
  function automatic int cpha_of(input int k); return (k == 2 || k == 4) ? 1 : 0; endfunction
  function automatic int lsb_of(input int k);  return (k == 5) ? 1 : 0;   endfunction

  generate
    for (genvar k = 0; k < N; k++) begin : g_dut
      localparam int W    = (k == 0) ? 8 : 16;
      localparam int MODE = (k >= 1 && k <= 4) ? k - 1 : 0;
      localparam int MSBF = (k == 5) ? 0 : 1;
      logic [W-1:0] rxd;
      spi_slave_param #(
        .DATA_W(W), .CPOL(MODE >> 1), .CPHA(MODE & 1), .MSB_FIRST(MSBF), .SYNC_STAGES(2)
      ) u_dut (
        .clock(clk), .rst(rst_n), .SCLK(sclk[k]), .SS(ss[k]), .MOSI(mosi),
        .MISO(miso_w[k]), .tx_data(txd[k][W-1:0]), .tx_valid(txv[k]), .tx_ready(txr[k]),
        .rx_data(rxd), .rx_valid(rxv[k]), .busy(bsy[k]), .tx_underrun(und[k]),
        .frame_done(fdn[k])
      );
      assign rxw[k] = 16'(rxd);
    end
  endgenerate

  int          rx_n [N];
  int          n_und [N];
  int          n_fd [N];
  logic [15:0] rx_log [N][16];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rxv[k] === 1'b1) begin
        if (rx_n[k] < 16) rx_log[k][rx_n[k]] <= rxw[k];
        rx_n[k] <= rx_n[k] + 1;
      end
      if (und[k] === 1'b1) n_und[k] <= n_und[k] + 1;
      if (fdn[k] === 1'b1) n_fd[k] <= n_fd[k] + 1;
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_hold(input int d, input logic [15:0] v);
    int n = 0;
    @(negedge clk);
    while (txr[d] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("tx_ready_wait", {31'b0, txr[d]}, 32'd1);
    txd[d] = v;
    txv[d] = 1'b1;
    @(negedge clk);
    txv[d] = 1'b0;
  endtask

  logic [15:0] mw [4];
  logic [15:0] sw [4];

  task automatic spi_frame(input int d, input int nbits, input int keep_ss,
                           input logic [15:0] m [4], output logic [15:0] s [4]);
    int w  = wid_of(d);
    int cp = cpol_of(d);
    int ph = cpha_of(d);
    int lb = lsb_of(d);
    int wi, pos;
    for (int i = 0; i < 4; i++) s[i] = '0;
    ss[d] = 1'b0;
    #(T);
    for (int b = 0; b < nbits; b++) begin
      wi  = b / w;
      pos = (lb != 0) ? (b % w) : (w - 1 - (b % w));
      if (ph == 0) begin
        mosi = m[wi][pos];
        #(T);
        sclk[d] = (cp == 0);
        s[wi][pos] = miso_w[d];
        #(T);
        sclk[d] = (cp != 0);
      end else begin
        sclk[d] = (cp == 0);
        mosi = m[wi][pos];
        #(T);
        sclk[d] = (cp != 0);
        s[wi][pos] = miso_w[d];
        #(T);
      end
    end
    if (keep_ss == 0) begin
      #(T);
      ss[d] = 1'b1;
      #(4 * T);
    end
  endtask

  int b_rx, b_fd, b_un;

  initial begin
    mosi = 1'b0;
    for (int k = 0; k < N; k++) begin
      sclk[k] = (cpol_of(k) != 0);
      ss[k]   = 1'b1;
      txd[k]  = '0;
      txv[k]  = 1'b0;
    end
    for (int i = 0; i < 4; i++) mw[i] = '0;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_miso", {31'b0, miso_w[0]}, 32'd0);
    chk("rst_tx_ready", {31'b0, txr[0]}, 32'd1);
    chk("rst_rx_data", {16'b0, rxw[0]}, 32'd0);
    chk("rst_busy", {31'b0, bsy[0]}, 32'd0);
    chk("rst_miso_cpol1", {31'b0, miso_w[3]}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // T1: mode 0, 8-bit
    load_hold(0, 16'h00A5);
    b_rx = rx_n[0]; b_fd = n_fd[0]; b_un = n_und[0];
    mw[0] = 16'h003C;
    spi_frame(0, 8, 0, mw, sw);
    chk("t1_master_rx", {16'b0, sw[0]}, 32'h00A5);
    chk("t1_rx_data", {16'b0, rxw[0]}, 32'h003C);
    chk("t1_rx_valid_cnt", rx_n[0] - b_rx, 32'd1);
    chk("t1_frame_done_cnt", n_fd[0] - b_fd, 32'd1);
    chk("t1_underrun_cnt", n_und[0] - b_un, 32'd0);
    chk("t1_busy_after", {31'b0, bsy[0]}, 32'd0);

    // T2: four modes at 16 bits, plus LSB-first
    for (int k = 1; k < N; k++) begin
      load_hold(k, 16'h1234);
      b_rx = rx_n[k];
      mw[0] = 16'hBEEF;
      spi_frame(k, 16, 0, mw, sw);
      chk($sformatf("t2_master_rx_dut%0d", k), {16'b0, sw[0]}, 32'h1234);
      chk($sformatf("t2_rx_data_dut%0d", k), {16'b0, rxw[k]}, 32'hBEEF);
      chk($sformatf("t2_rx_valid_cnt_dut%0d", k), rx_n[k] - b_rx, 32'd1);
    end

    // T3: three-word frame with refills
    load_hold(0, 16'h0011);
    b_rx = rx_n[0]; b_un = n_und[0];
    mw[0] = 16'h00C1; mw[1] = 16'h005A; mw[2] = 16'h007E;
    fork
      spi_frame(0, 24, 0, mw, sw);
      begin
        load_hold(0, 16'h0022);
        load_hold(0, 16'h0033);
      end
    join
    chk("t3_master_w0", {16'b0, sw[0]}, 32'h0011);
    chk("t3_master_w1", {16'b0, sw[1]}, 32'h0022);
    chk("t3_master_w2", {16'b0, sw[2]}, 32'h0033);
    chk("t3_rx_valid_cnt", rx_n[0] - b_rx, 32'd3);
    chk("t3_rx_w0", {16'b0, rx_log[0][b_rx]}, 32'h00C1);
    chk("t3_rx_w1", {16'b0, rx_log[0][b_rx+1]}, 32'h005A);
    chk("t3_rx_w2", {16'b0, rx_log[0][b_rx+2]}, 32'h007E);
    chk("t3_underrun_cnt", n_und[0] - b_un, 32'd0);

    // T4: two words with nothing loaded
    b_rx = rx_n[0]; b_un = n_und[0];
    mw[0] = 16'h000F; mw[1] = 16'h00F0;
    spi_frame(0, 16, 0, mw, sw);
    chk("t4_master_w0", {16'b0, sw[0]}, 32'h0000);
    chk("t4_master_w1", {16'b0, sw[1]}, 32'h0000);
    chk("t4_underrun_cnt", n_und[0] - b_un, 32'd2);
    chk("t4_rx_w1", {16'b0, rx_log[0][b_rx+1]}, 32'h00F0);

    // T5: frame aborted after 5 bits, then a full frame
    b_rx = rx_n[0]; b_fd = n_fd[0];
    mw[0] = 16'h00FF;
    spi_frame(0, 5, 0, mw, sw);
    chk("t5_rx_valid_cnt", rx_n[0] - b_rx, 32'd0);
    chk("t5_rx_held", {16'b0, rxw[0]}, 32'h00F0);
    chk("t5_frame_done_cnt", n_fd[0] - b_fd, 32'd1);
    chk("t5_miso_idle", {31'b0, miso_w[0]}, 32'd0);
    mw[0] = 16'h0081;
    spi_frame(0, 8, 0, mw, sw);
    chk("t5_rx_next", {16'b0, rxw[0]}, 32'h0081);
    chk("t5_rx_valid_next", rx_n[0] - b_rx, 32'd1);

    // T6: reset in the middle of a word
    load_hold(0, 16'h005A);
    mw[0] = 16'h00C3;
    spi_frame(0, 4, 1, mw, sw);
    repeat (10) @(negedge clk);
    chk("t6_busy_mid", {31'b0, bsy[0]}, 32'd1);
    chk("t6_miso_mid", {31'b0, miso_w[0]}, 32'd1);
    chk("t6_master_partial", {16'b0, sw[0]}, 32'h0050);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_miso", {31'b0, miso_w[0]}, 32'd0);
    chk("t6_rst_tx_ready", {31'b0, txr[0]}, 32'd1);
    chk("t6_rst_rx_data", {16'b0, rxw[0]}, 32'd0);
    chk("t6_rst_rx_valid", {31'b0, rxv[0]}, 32'd0);
    chk("t6_rst_busy", {31'b0, bsy[0]}, 32'd0);
    chk("t6_rst_underrun", {31'b0, und[0]}, 32'd0);
    chk("t6_rst_frame_done", {31'b0, fdn[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_rx = rx_n[0]; b_fd = n_fd[0];
    for (int i = 0; i < 4; i++) begin
      #(T); sclk[0] = 1'b1;
      #(T); sclk[0] = 1'b0;
    end
    #(T);
    chk("t6_no_resume_busy", {31'b0, bsy[0]}, 32'd0);
    ss[0] = 1'b1;
    #(4 * T);
    chk("t6_no_resume_rx", rx_n[0] - b_rx, 32'd0);
    chk("t6_no_frame_done", n_fd[0] - b_fd, 32'd0);
    mw[0] = 16'h0042;
    spi_frame(0, 8, 0, mw, sw);
    chk("t6_after_rx", {16'b0, rxw[0]}, 32'h0042);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
